// File: rtl/door_ctrl_timed.sv
// door_ctrl_timed: automatic-door FSM with hold timer, limit-switch feedback,
// travel-timeout fault and reopen-on-obstruction.
module door_ctrl_timed #(
  parameter int N_SENSORS   = 2,
  parameter int HOLD_CYCLES = 100,
  parameter int TRAVEL_MAX  = 50,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SENSORS-1:0] sensor,
  input  logic                 lock,
  input  logic                 open_limit,
  input  logic                 closed_limit,
  input  logic                 fault_clr,
  output logic                 motor_open,
  output logic                 motor_close,
  output logic [2:0]           door_state,
  output logic                 fault,
  output logic [7:0]           reopen_cnt
);
  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  state_t           state, nxt;
  logic [CNT_W-1:0] timer;
  logic             presence, both, travel_end, restart, reverse;
  assign presence   = |sensor;
  assign both       = open_limit && closed_limit;
  assign travel_end = timer == TRAVEL_LAST;
  always_comb begin
    nxt     = state;
    restart = 1'b0;
    reverse = 1'b0;
    case (state)
      CLOSED:  nxt = presence && !lock ? OPENING : CLOSED;
      OPENING: nxt = both ? FAULT : open_limit ? OPEN : travel_end ? FAULT : OPENING;
      OPEN: begin
        restart = presence;
        nxt     = !presence && timer == HOLD_LAST ? CLOSING : OPEN;
      end
      CLOSING: begin
        // presence outranks closed_limit so an obstruction always reverses
        reverse = !both && presence;
        nxt     = both ? FAULT : presence ? OPENING : closed_limit ? CLOSED :
                  travel_end ? FAULT : CLOSING;
      end
      FAULT:   nxt = !fault_clr ? FAULT : closed_limit ? CLOSED : CLOSING;
      default: nxt = CLOSED;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLOSED;
      timer      <= '0;
      reopen_cnt <= '0;
    end else begin
      state      <= nxt;
      timer      <= (nxt != state || restart) ? '0 : &timer ? timer : timer + CNT_W'(1);
      reopen_cnt <= reverse && reopen_cnt != 8'hff ? reopen_cnt + 8'd1 : reopen_cnt;
    end
  end
  assign motor_open  = state == OPENING;
  assign motor_close = state == CLOSING;
  assign fault       = state == FAULT;
  assign door_state  = state;
endmodule

// File: tb/tb_door_ctrl_timed.sv
// tb_door_ctrl_timed: directed scenarios plus randomized traffic checked
// against a behavioural door model.
module tb_door_ctrl_timed;
  localparam int HOLD   = 4;
  localparam int TRAVEL = 6;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sensor = '0;
  logic       lock = 1'b0, open_limit = 1'b0, closed_limit = 1'b0, fault_clr = 1'b0;
  logic       motor_open, motor_close, fault;
  logic [2:0] door_state;
  logic [7:0] reopen_cnt;
  int total = 0;
  int bad   = 0;
  // model: state code, cycles spent in current state, reversal count
  int m_st = 0, m_age = 0, m_rev = 0;

  door_ctrl_timed #(.N_SENSORS(2), .HOLD_CYCLES(HOLD), .TRAVEL_MAX(TRAVEL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .lock(lock), .open_limit(open_limit),
    .closed_limit(closed_limit), .fault_clr(fault_clr), .motor_open(motor_open),
    .motor_close(motor_close), .door_state(door_state), .fault(fault), .reopen_cnt(reopen_cnt)
  );

  always #5 clk = ~clk;

  task automatic model(input bit p, input bit lk, input bit ol, input bit cl, input bit fc);
    int  ns;
    bit  restart;
    ns      = m_st;
    restart = 1'b0;
    case (m_st)
      0: if (p && !lk) ns = 1;
      1: if (ol && cl) ns = 4; else if (ol) ns = 2; else if (m_age + 1 == TRAVEL) ns = 4;
      2: if (p) restart = 1'b1; else if (m_age + 1 == HOLD) ns = 3;
      3: if (ol && cl) ns = 4;
         else if (p) begin ns = 1; m_rev = m_rev < 255 ? m_rev + 1 : 255; end
         else if (cl) ns = 0;
         else if (m_age + 1 == TRAVEL) ns = 4;
      4: if (fc) ns = cl ? 0 : 3;
      default: ns = 0;
    endcase
    m_age = (ns != m_st || restart) ? 0 : m_age + 1;
    m_st  = ns;
  endtask

  task automatic step(input logic [1:0] s, input logic lk, input logic ol, input logic cl, input logic fc);
    sensor = s; lock = lk; open_limit = ol; closed_limit = cl; fault_clr = fc;
    @(posedge clk);
    model(s != 2'b00, lk, ol, cl, fc);
    #1;
  endtask

  task automatic do_reset();
    sensor = '0; lock = 0; open_limit = 0; closed_limit = 0; fault_clr = 0;
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    m_st = 0; m_age = 0; m_rev = 0;
  endtask

  task automatic to_open();
    step(2'b01, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 1, 0, 0);
  endtask

  task automatic to_closing();
    to_open();
    repeat (HOLD) step(2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (door_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", door_state); end
    total++; if ({motor_open, motor_close, fault} !== 3'b000) begin bad++; $display("FAIL reset_outs got=%b want=000", {motor_open, motor_close, fault}); end
    total++; if (reopen_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", reopen_cnt); end
    @(negedge clk);
    rst = 1'b0;
    step(2'b00, 0, 0, 0, 0);
    total++; if (door_state !== 3'd0) begin bad++; $display("FAIL reset_idle got=%0d want=0", door_state); end
  endtask

  task automatic test_normal();
    int exp_seq[10] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 0};
    int n_open = 0, n_close = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(i == 0 ? 2'b01 : 2'b00, 0, i == 3, i == 9, 0);
      total++; if (door_state !== 3'(exp_seq[i])) begin bad++; $display("FAIL normal_seq[%0d] got=%0d want=%0d", i, door_state, exp_seq[i]); end
      n_open  += int'(motor_open);
      n_close += int'(motor_close);
    end
    total++; if (n_open != 3) begin bad++; $display("FAIL normal_open_cycles got=%0d want=3", n_open); end
    total++; if (n_close != 2) begin bad++; $display("FAIL normal_close_cycles got=%0d want=2", n_close); end
  endtask

  task automatic test_hold_ext();
    int n = 1;
    do_reset();
    to_open();
    for (int i = 1; i <= 20 && door_state == 3'd2; i++) begin
      step(i == 4 ? 2'b10 : 2'b00, 0, 0, 0, 0);
      if (door_state == 3'd2) n++;
    end
    total++; if (n != 2 * HOLD) begin bad++; $display("FAIL hold_ext_dwell got=%0d want=%0d", n, 2 * HOLD); end
    total++; if (door_state !== 3'd3) begin bad++; $display("FAIL hold_ext_next got=%0d want=3", door_state); end
  endtask

  task automatic test_reversal();
    do_reset();
    to_closing();
    step(2'b11, 0, 0, 1, 0);
    total++; if (door_state !== 3'd1) begin bad++; $display("FAIL reversal_state got=%0d want=1", door_state); end
    total++; if (reopen_cnt !== 8'd1) begin bad++; $display("FAIL reversal_cnt got=%0d want=1", reopen_cnt); end
    for (int i = 1; i < 300; i++) begin
      step(2'b00, 0, 1, 0, 0);
      repeat (HOLD) step(2'b00, 0, 0, 0, 0);
      step(2'b11, 0, 0, 1, 0);
      total++; if (reopen_cnt !== 8'(m_rev) || door_state !== 3'd1) begin bad++; $display("FAIL reversal_iter[%0d] got=%0d/%0d want=%0d/1", i, reopen_cnt, door_state, m_rev); end
    end
    total++; if (reopen_cnt !== 8'd255) begin bad++; $display("FAIL reversal_sat got=%0d want=255", reopen_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    step(2'b01, 0, 0, 0, 0);
    for (int i = 1; i <= TRAVEL; i++) begin
      step(2'b00, 0, 0, 0, 0);
      total++; if (door_state !== (i == TRAVEL ? 3'd4 : 3'd1)) begin bad++; $display("FAIL timeout_seq[%0d] got=%0d want=%0d", i, door_state, i == TRAVEL ? 4 : 1); end
    end
    total++; if ({fault, motor_open, motor_close} !== 3'b100) begin bad++; $display("FAIL timeout_outs got=%b want=100", {fault, motor_open, motor_close}); end
    step(2'b11, 0, 1, 1, 0);
    total++; if (door_state !== 3'd4) begin bad++; $display("FAIL fault_ignore got=%0d want=4", door_state); end
    step(2'b00, 0, 0, 0, 1);
    total++; if (door_state !== 3'd3 || motor_close !== 1'b1) begin bad++; $display("FAIL fault_clr_closing got=%0d/%b want=3/1", door_state, motor_close); end
    step(2'b00, 0, 0, 1, 0);
    total++; if (door_state !== 3'd0 || fault !== 1'b0) begin bad++; $display("FAIL fault_recover got=%0d/%b want=0/0", door_state, fault); end
  endtask

  task automatic test_lock();
    int stuck = 0;
    do_reset();
    repeat (20) begin
      step(2'b01, 1, 0, 0, 0);
      if (door_state !== 3'd0 || motor_open !== 1'b0) stuck++;
    end
    total++; if (stuck != 0) begin bad++; $display("FAIL lock_hold got=%0d leaks want=0", stuck); end
    step(2'b01, 0, 0, 0, 0);
    total++; if (door_state !== 3'd1) begin bad++; $display("FAIL lock_release got=%0d want=1", door_state); end
  endtask

  task automatic test_inconsistent();
    do_reset();
    to_closing();
    step(2'b00, 0, 1, 1, 0);
    total++; if (door_state !== 3'd4 || fault !== 1'b1) begin bad++; $display("FAIL both_limits got=%0d/%b want=4/1", door_state, fault); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(2'b01, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0);
    total++; if (motor_open !== 1'b1) begin bad++; $display("FAIL async_pre got=%b want=1", motor_open); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (motor_open !== 1'b0) begin bad++; $display("FAIL async_motor got=%b want=0", motor_open); end
    total++; if ({door_state, motor_close, fault, reopen_cnt} !== 13'd0) begin bad++; $display("FAIL async_outs got=%0d/%b/%b/%0d want=0", door_state, motor_close, fault, reopen_cnt); end
    @(negedge clk);
    rst = 1'b0;
    m_st = 0; m_age = 0; m_rev = 0;
  endtask

  task automatic test_random();
    int errs = 0;
    logic [1:0] s;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      s = ($urandom % 6 == 0) ? 2'($urandom) : 2'b00;
      step(s, $urandom % 3 == 0, $urandom % 4 == 0, $urandom % 4 == 0, $urandom % 4 == 0);
      total++;
      if (door_state !== 3'(m_st) || motor_open !== (m_st == 1) || motor_close !== (m_st == 3) ||
          fault !== (m_st == 4) || reopen_cnt !== 8'(m_rev)) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL random[%0d] got st=%0d cnt=%0d mo=%b mc=%b f=%b want st=%0d cnt=%0d",
                                i, door_state, reopen_cnt, motor_open, motor_close, fault, m_st, m_rev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_hold_ext();
    test_reversal();
    test_timeout();
    test_lock();
    test_inconsistent();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/door_ctrl_timed.md
# door_ctrl_timed

Parametrised automatic-door controller with an internal hold timer, limit-switch feedback, travel-timeout fault detection and reopen-on-obstruction. It replaces the single-sensor, externally-timed door FSM. Outputs are registered Moore outputs driving a bidirectional door motor driver. It sits between the synchronised sensor/limit-switch inputs and the motor driver stage.

## Interface
- N_SENSORS, default 2: number of presence sensors; any asserted sensor counts as presence.
- HOLD_CYCLES, default 100: cycles the door stays open after the last presence; must be at least 1.
- TRAVEL_MAX, default 50: maximum cycles allowed for opening or closing travel; must be at least 1.
- CNT_W, default 16: timer width; 2^CNT_W must exceed max(HOLD_CYCLES, TRAVEL_MAX).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- sensor  in  N_SENSORS  presence sensors, active-high
- lock  in  1  1 = inhibit opening from CLOSED
- open_limit  in  1  door fully open
- closed_limit  in  1  door fully closed
- fault_clr  in  1  single-cycle fault acknowledge
- motor_open  out  1  drive door toward open
- motor_close  out  1  drive door toward closed
- door_state  out  3  encoded state
- fault  out  1  1 while in FAULT
- reopen_cnt  out  8  saturating count of closing reversals

## Operation
- Input synchronisation is done upstream; all inputs are synchronous to clk. presence = OR of all sensor bits.
- State encodings: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4. Codes 5–7 go to CLOSED on the next edge.
- The timer is cleared on every state change and increments each cycle the state holds.
- Outputs decode from the state register only:
  - motor_open = (state==OPENING)
  - motor_close = (state==CLOSING)
  - fault = (state==FAULT)
  - motor_open and motor_close are never both 1.
- CLOSED: if presence && !lock, go to OPENING. Otherwise stay.
- OPENING, evaluated in priority order:
  - open_limit && closed_limit → FAULT
  - open_limit → OPEN
  - timer==TRAVEL_MAX-1 → FAULT
  - otherwise stay
- OPEN:
  - presence clears the timer and the state stays.
  - Otherwise, timer==HOLD_CYCLES-1 → CLOSING.
  - lock has no effect in OPEN.
- CLOSING, evaluated in priority order:
  - both limits high → FAULT
  - presence → OPENING; reopen_cnt increments and saturates at 255
  - closed_limit → CLOSED
  - timer==TRAVEL_MAX-1 → FAULT
  - presence overrides a simultaneous closed_limit.
- FAULT:
  - Motors are off; all inputs are ignored except fault_clr.
  - On fault_clr: if closed_limit, go to CLOSED; else go to CLOSING with a fresh timer.
- lock affects only the CLOSED exit. It never stops motion and never blocks a CLOSING reversal.

## Timing
- Reset values: state=CLOSED, timer=0, reopen_cnt=0, motor_open=0, motor_close=0, fault=0, door_state=0.
- Reset mid-travel immediately de-asserts both motor outputs.
- Latency: an input sampled at edge k changes state at edge k, so outputs change after edge k (one-cycle input-to-output latency).
- OPEN dwell without presence is exactly HOLD_CYCLES cycles. Presence on the last cycle restarts a full HOLD_CYCLES.
- Travel timeout: FAULT is entered after exactly TRAVEL_MAX cycles in OPENING or CLOSING without the required limit.
- A limit asserted on the same cycle as timer==TRAVEL_MAX-1 wins; no fault.
- fault_clr outside FAULT is ignored.

## Test plan
All scenarios use N_SENSORS=2, HOLD_CYCLES=4, TRAVEL_MAX=6.

- Normal cycle:
  - Stimulus: sensor=01 for 1 cycle; open_limit after 3 cycles; closed_limit 2 cycles into closing.
  - Required: door_state sequence 0→1 (3 cycles)→2 (exactly 4 cycles)→3 (2 cycles)→0. motor_open high 3 cycles; motor_close high 2 cycles.
- Hold extension:
  - Stimulus: in OPEN, sensor=10 pulsed on dwell cycle 4.
  - Required: OPEN lasts 4+4=8 cycles total before CLOSING.
- Reversal:
  - Stimulus: in CLOSING, sensor=11 on the same cycle as closed_limit.
  - Required: next state OPENING; reopen_cnt 0→1.
  - Repeating the reversal 300 times leaves reopen_cnt at 255.
- Travel timeout:
  - Stimulus: OPENING with no open_limit.
  - Required: FAULT after 6 cycles; fault=1; motors 0.
  - Then fault_clr with closed_limit=0 → CLOSING; then closed_limit → CLOSED, fault=0.
- Lock and inconsistency:
  - Stimulus 1: lock=1 in CLOSED with sensor=01.
  - Required 1: stays CLOSED indefinitely.
  - Stimulus 2: in CLOSING, both limits set.
  - Required 2: FAULT on the next edge.
- Async reset:
  - Stimulus: rst asserted mid-OPENING between clock edges.
  - Required: motor_open drops without waiting for a clock edge; all outputs at reset values.
